// File: rtl/axa_adder.sv
// axa_adder: element-wise 2x2 matrix addition C = A + B in IEEE-754 binary32.
// One shared round-to-nearest-even adder evaluates C11, C12, C21, C22 on
// consecutive cycles. output_Stable marks a complete result, which is held
// until the consumer acknowledges it.
// Build option: define AXA_DENORMAL_EN for gradual underflow. Without it,
// subnormal operands are read as signed zero and subnormal results are
// flushed to signed zero.
module axa_adder (
    input  logic        input_Clk,
    input  logic        input_Reset,
    input  logic        input_Start,
    input  logic        input_C_Ack,
    input  logic [31:0] input_A11,
    input  logic [31:0] input_A12,
    input  logic [31:0] input_A21,
    input  logic [31:0] input_A22,
    input  logic [31:0] input_B11,
    input  logic [31:0] input_B12,
    input  logic [31:0] input_B21,
    input  logic [31:0] input_B22,
    output logic        output_Stable,
    output logic [31:0] output_C11,
    output logic [31:0] output_C12,
    output logic [31:0] output_C21,
    output logic [31:0] output_C22
);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t      state_q, state_d;
    logic        load_en, calc_en;
    logic [31:0] a_q [4];
    logic [31:0] b_q [4];
    logic [31:0] c_q [4];
    logic [1:0]  idx_q;
    logic        stable_q;
    logic [31:0] sum;

    // Binary32 addition, round to nearest even. The smaller operand is
    // aligned into a 27-bit field (24 significand bits + guard, round,
    // sticky) before the add/subtract.
    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic               sa, sb, sx, sy;
        logic               nan_a, nan_b, inf_a, inf_b, za, zb;
        logic [7:0]         ea, eb, ex, ey, d;
        logic [23:0]        siga, sigb, sigx, sigy;
        logic [5:0]         dsh;
        logic [49:0]        wide;
        logic [26:0]        ax, ay, m;
        logic [27:0]        s28;
        logic [4:0]         lz, sh;
        logic               found, rup;
        logic [24:0]        mant25;
        logic [23:0]        mant;
        logic signed [9:0]  e;

        sa    = a[31];
        sb    = b[31];
        nan_a = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        nan_b = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        inf_a = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        inf_b = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
`ifdef AXA_DENORMAL_EN
        // Subnormals share the minimum exponent and carry no hidden bit.
        za   = (a[30:23] == 8'd0) && (a[22:0] == 23'd0);
        zb   = (b[30:23] == 8'd0) && (b[22:0] == 23'd0);
        ea   = (a[30:23] == 8'd0) ? 8'd1 : a[30:23];
        eb   = (b[30:23] == 8'd0) ? 8'd1 : b[30:23];
        siga = {a[30:23] != 8'd0, a[22:0]};
        sigb = {b[30:23] != 8'd0, b[22:0]};
`else
        // Any zero exponent field reads as a signed zero.
        za   = (a[30:23] == 8'd0);
        zb   = (b[30:23] == 8'd0);
        ea   = a[30:23];
        eb   = b[30:23];
        siga = {1'b1, a[22:0]};
        sigb = {1'b1, b[22:0]};
`endif

        if (nan_a || nan_b || (inf_a && inf_b && (sa != sb)))
            return 32'h7FC00000;
        if (inf_a)
            return {sa, 8'hFF, 23'd0};
        if (inf_b)
            return {sb, 8'hFF, 23'd0};
        if (za && zb)
            return {sa & sb, 31'd0};
        if (za)
            return b;
        if (zb)
            return a;

        // x is the operand of larger magnitude and fixes the result sign.
        if ({ea, siga} >= {eb, sigb}) begin
            sx = sa; ex = ea; sigx = siga;
            sy = sb; ey = eb; sigy = sigb;
        end else begin
            sx = sb; ex = eb; sigx = sigb;
            sy = sa; ey = ea; sigy = siga;
        end

        // Align; every bit shifted past the round position folds into sticky.
        d    = ex - ey;
        dsh  = (d > 8'd49) ? 6'd49 : d[5:0];
        wide = {sigy, 26'd0} >> dsh;
        ax   = {sigx, 3'b000};
        ay   = {wide[49:24], |wide[23:0]};
        e    = signed'({2'b00, ex});

        if (sx == sy) begin
            s28 = {1'b0, ax} + {1'b0, ay};
            if (s28[27]) begin
                m = {s28[27:2], s28[1] | s28[0]};
                e = e + 10'sd1;
            end else begin
                m = s28[26:0];
            end
        end else begin
            s28 = '0;
            m   = ax - ay;
        end

        if (m == 27'd0)
            return 32'h00000000;

        // Renormalise after cancellation.
        lz    = 5'd0;
        found = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!found) begin
                if (m[i]) found = 1'b1;
                else      lz    = lz + 5'd1;
            end
        end
`ifdef AXA_DENORMAL_EN
        // Stop at the minimum exponent: the result becomes subnormal.
        if (signed'({5'b00000, lz}) >= e) sh = 5'(e - 10'sd1);
        else                              sh = lz;
        m = m << sh;
        e = e - signed'({5'b00000, sh});
`else
        sh = lz;
        m  = m << sh;
        e  = e - signed'({5'b00000, sh});
        if (e < 10'sd1)
            return {sx, 31'd0};
`endif

        rup    = m[2] & (m[1] | m[0] | m[3]);
        mant25 = {1'b0, m[26:3]} + {24'd0, rup};
        if (mant25[24]) begin
            mant = mant25[24:1];
            e    = e + 10'sd1;
        end else begin
            mant = mant25[23:0];
        end

        if (e >= 10'sd255)
            return {sx, 8'hFF, 23'd0};
        // A missing hidden bit means a subnormal encoding (exponent field 0).
        return {sx, mant[23] ? e[7:0] : 8'h00, mant[22:0]};
    endfunction

    // State register
    always_ff @(posedge input_Clk) begin
        if (input_Reset) state_q <= S_IDLE;
        else             state_q <= state_d;
    end

    // Next-state logic: Start only matters in IDLE, C_Ack only in DONE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (input_Start)    state_d = S_CALC;
            S_CALC:  if (idx_q == 2'd3)  state_d = S_DONE;
            S_DONE:  if (input_C_Ack)    state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
    end

    // Output decode: datapath strobes
    always_comb begin
        load_en = (state_q == S_IDLE) && input_Start;
        calc_en = (state_q == S_CALC);
    end

    // Shared adder works on the element selected by the index
    always_comb begin
        sum = fp_add(a_q[idx_q], b_q[idx_q]);
    end

    // Operand capture and element index
    always_ff @(posedge input_Clk) begin
        if (input_Reset) begin
            for (int i = 0; i < 4; i++) begin
                a_q[i] <= 32'd0;
                b_q[i] <= 32'd0;
            end
            idx_q <= 2'd0;
        end else if (load_en) begin
            a_q[0] <= input_A11;
            a_q[1] <= input_A12;
            a_q[2] <= input_A21;
            a_q[3] <= input_A22;
            b_q[0] <= input_B11;
            b_q[1] <= input_B12;
            b_q[2] <= input_B21;
            b_q[3] <= input_B22;
            idx_q  <= 2'd0;
        end else if (calc_en) begin
            idx_q <= idx_q + 2'd1;
        end
    end

    // Result registers, one element written per CALC cycle
    always_ff @(posedge input_Clk) begin
        if (input_Reset) begin
            for (int i = 0; i < 4; i++) c_q[i] <= 32'd0;
        end else if (calc_en) begin
            c_q[idx_q] <= sum;
        end
    end

    // Stable flag registered alongside the DONE state
    always_ff @(posedge input_Clk) begin
        if (input_Reset) stable_q <= 1'b0;
        else             stable_q <= (state_d == S_DONE);
    end

    assign output_Stable = stable_q;
    assign output_C11    = c_q[0];
    assign output_C12    = c_q[1];
    assign output_C21    = c_q[2];
    assign output_C22    = c_q[3];

endmodule

// File: tb/tb_axa_adder.sv
// Bench for axa_adder: directed steps with a scoreboard of expected C tuples.
// Expected sums come from an exact big-integer model of binary32 addition.
module tb_axa_adder;

    logic        clk = 1'b0;
    logic        rst, start, ack;
    logic [31:0] a_in [4];
    logic [31:0] b_in [4];
    logic        stable;
    logic [31:0] c11, c12, c21, c22;

    int           checks   = 0;
    int           failures = 0;
    logic [127:0] sb [$];
    logic [127:0] last_exp = '0;

    always #5 clk = ~clk;

    axa_adder dut (
        .input_Clk     (clk),
        .input_Reset   (rst),
        .input_Start   (start),
        .input_C_Ack   (ack),
        .input_A11     (a_in[0]),
        .input_A12     (a_in[1]),
        .input_A21     (a_in[2]),
        .input_A22     (a_in[3]),
        .input_B11     (b_in[0]),
        .input_B12     (b_in[1]),
        .input_B21     (b_in[2]),
        .input_B22     (b_in[3]),
        .output_Stable (stable),
        .output_C11    (c11),
        .output_C12    (c12),
        .output_C21    (c21),
        .output_C22    (c22)
    );

    // Exact model: operands become integers in units of 2^-149, are summed
    // exactly, and the sum is rounded once to 24 significant bits.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic [299:0] va, vb, mag, keep, rem, half, one;
        logic [23:0]  ma, mb;
        logic         sa, sb2, sr, found;
        int           ea, eb, p, s, e;
        sa  = a[31];
        sb2 = b[31];
        ea  = int'(a[30:23]);
        eb  = int'(b[30:23]);
        one = 300'd1;
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC00000;
        if (ea == 255 && eb == 255) return (sa == sb2) ? a : 32'h7FC00000;
        if (ea == 255) return a;
        if (eb == 255) return b;
`ifdef AXA_DENORMAL_EN
        ma = (ea == 0) ? {1'b0, a[22:0]} : {1'b1, a[22:0]};
        mb = (eb == 0) ? {1'b0, b[22:0]} : {1'b1, b[22:0]};
`else
        ma = (ea == 0) ? 24'd0 : {1'b1, a[22:0]};
        mb = (eb == 0) ? 24'd0 : {1'b1, b[22:0]};
`endif
        va = 300'(ma) << ((ea == 0) ? 0 : ea - 1);
        vb = 300'(mb) << ((eb == 0) ? 0 : eb - 1);
        if (sa == sb2)   begin mag = va + vb; sr = sa;  end
        else if (va >= vb) begin mag = va - vb; sr = sa;  end
        else             begin mag = vb - va; sr = sb2; end
        if (mag == 0) return {sa & sb2, 31'd0};
        p = 0;
        found = 1'b0;
        for (int i = 299; i >= 0; i--) begin
            if (!found && mag[i]) begin
                p = i;
                found = 1'b1;
            end
        end
        if (p < 23) begin
`ifdef AXA_DENORMAL_EN
            return {sr, 8'h00, mag[22:0]};
`else
            return {sr, 31'd0};
`endif
        end
        e = p - 22;
        if (p == 23) begin
            keep = mag;
        end else begin
            s    = p - 23;
            keep = mag >> s;
            rem  = mag - (keep << s);
            half = one << (s - 1);
            if (rem > half || (rem == half && keep[0])) keep = keep + one;
        end
        if (keep[24]) begin
            keep = keep >> 1;
            e    = e + 1;
        end
        if (e >= 255) return {sr, 8'hFF, 23'd0};
        return {sr, 8'(e), keep[22:0]};
    endfunction

    function automatic logic [127:0] model4();
        return {ref_add(a_in[0], b_in[0]), ref_add(a_in[1], b_in[1]),
                ref_add(a_in[2], b_in[2]), ref_add(a_in[3], b_in[3])};
    endfunction

    function automatic logic [127:0] cvec();
        return {c11, c12, c21, c22};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic set_ops(input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] a2, input logic [31:0] a3,
                           input logic [31:0] b0, input logic [31:0] b1,
                           input logic [31:0] b2, input logic [31:0] b3);
        a_in[0] = a0; a_in[1] = a1; a_in[2] = a2; a_in[3] = a3;
        b_in[0] = b0; b_in[1] = b1; b_in[2] = b2; b_in[3] = b3;
    endtask

    task automatic scramble();
        for (int k = 0; k < 4; k++) begin
            a_in[k] = $urandom;
            b_in[k] = $urandom;
        end
    endtask

    task automatic start_op(input logic [127:0] expv);
        sb.push_back(expv);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Wait (bounded) for Stable, then pop the scoreboard and compare.
    task automatic collect(input string tag, input bit check_lat);
        int cyc;
        cyc = 0;
        while (stable !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk({tag, "_stable"}, 128'(stable), 128'(1));
        if (check_lat) chk({tag, "_latency"}, 128'(cyc), 128'(4));
        chk({tag, "_sb_depth_ok"}, 128'(sb.size() > 0), 128'(1));
        if (sb.size() > 0) begin
            last_exp = sb.pop_front();
            chk({tag, "_C"}, cvec(), last_exp);
        end
    endtask

    task automatic ack_op(input string tag);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk({tag, "_stable_low"}, 128'(stable), 128'(0));
    endtask

    initial begin
        logic [31:0] ra, rb;
        int          ee;

        rst = 1'b1; start = 1'b0; ack = 1'b0;
        set_ops(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        chk("reset_stable", 128'(stable), 128'(0));
        chk("reset_C", cvec(), 128'd0);
        rst = 1'b0;
        tick();

        // Reference vector; inputs are scrambled right after capture.
        set_ops(32'h42FA0000, 32'h3EE04189, 32'h420A28F6, 32'h4148BC6A,
                32'h3A635B85, 32'h44961DC3, 32'h41980000, 32'h3FAB851F);
        start_op(model4());
        scramble();
        collect("vec027", 1'b1);
        ack_op("vec027_ack");

        // Basic sums, exact cancellation, overflow, inf - inf.
        set_ops(32'h3F800000, 32'h3FC00000, 32'h7F7FFFFF, 32'h7F800000,
                32'h40000000, 32'hBFC00000, 32'h7F7FFFFF, 32'hFF800000);
        start_op({32'h40400000, 32'h00000000, 32'h7F800000, 32'h7FC00000});
        collect("vec028", 1'b1);

        // Result must hold while unacknowledged, whatever the inputs do.
        for (int n = 0; n < 10; n++) begin
            scramble();
            start = n[0];
            tick();
            chk("hold_stable", 128'(stable), 128'(1));
            chk("hold_C", cvec(), last_exp);
        end
        start = 1'b0;
        ack_op("hold_ack");
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("idle_stable", 128'(stable), 128'(0));
        chk("idle_C_retained", cvec(), last_exp);

        // Subnormal sum, (-0)+(-0), equal-magnitude subnormals, RNE tie.
`ifdef AXA_DENORMAL_EN
        ra = 32'h00800000;
`else
        ra = 32'h00000000;
`endif
        set_ops(32'h00400000, 32'h80000000, 32'h00000001, 32'h3F800001,
                32'h00400000, 32'h80000000, 32'h80000001, 32'hB3800000);
        start_op({ra, 32'h80000000, 32'h00000000, 32'h3F800000});
        collect("denorm", 1'b1);
        ack_op("denorm_ack");

        // Overflow by rounding, NaN operand, single infinity, tie to even.
        set_ops(32'h7F7FFFFF, 32'h7FC00001, 32'hFF800000, 32'h4B000000,
                32'h73000000, 32'h3F800000, 32'h3F800000, 32'h3F000000);
        start_op({32'h7F800000, 32'h7FC00000, 32'hFF800000, 32'h4B000000});
        collect("special", 1'b1);
        ack_op("special_ack");

        // Random operands with nearby exponents, far exponents, cancellation.
        for (int n = 0; n < 6; n++) begin
            for (int k = 0; k < 4; k++) begin
                ee = int'($urandom_range(110, 140));
                ra = {1'($urandom), 8'(ee), 23'($urandom)};
                if (k == 3)
                    rb = {~ra[31], ra[30:1], ~ra[0]};
                else if (k == 2 && (n % 2) == 1)
                    rb = {1'($urandom), 8'(ee - 40), 23'($urandom)};
                else
                    rb = {1'($urandom), 8'(ee + int'($urandom_range(0, 30)) - 15), 23'($urandom)};
                a_in[k] = ra;
                b_in[k] = rb;
            end
            start_op(model4());
            collect("rand", 1'b1);
            ack_op("rand_ack");
        end

        // Reset during the second CALC cycle discards the operation.
        set_ops(32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000,
                32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3F800000);
        start_op(model4());
        tick();
        rst = 1'b1;
        tick();
        chk("midreset_stable", 128'(stable), 128'(0));
        chk("midreset_C", cvec(), 128'd0);
        rst = 1'b0;
        sb.delete();
        tick();
        chk("postreset_stable", 128'(stable), 128'(0));
        start_op(model4());
        collect("postreset", 1'b1);
        ack_op("postreset_ack");

        // Start held high: each result waits for its ack, with a gap.
        set_ops(32'h41200000, 32'hC1200000, 32'h3DCCCCCD, 32'h447A0000,
                32'h3F000000, 32'h41200000, 32'h3E4CCCCD, 32'hC47A0001);
        sb.push_back(model4());
        sb.push_back(model4());
        start = 1'b1;
        tick();
        collect("held1", 1'b1);
        tick();
        chk("held_no_restart_stable", 128'(stable), 128'(1));
        chk("held_no_restart_C", cvec(), last_exp);
        ack_op("held1_ack");
        tick();
        chk("held_gap_stable", 128'(stable), 128'(0));
        collect("held2", 1'b0);
        start = 1'b0;
        ack_op("held2_ack");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axa_adder.md
AXA_ADDER -- requirements
Module: axa_adder

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 32 bits (IEEE-754 binary32).
REQ-002 input_Clk  in  1  single clock; all state changes on its rising edge.
REQ-003 input_Reset  in  1  synchronous, active-high reset.
REQ-004 input_Start  in  1  request to begin one addition C = A + B.
REQ-005 input_C_Ack  in  1  consumer acknowledge of a stable result.
REQ-006 input_A11, input_A12, input_A21, input_A22  in  32 each  matrix A elements (binary32).
REQ-007 input_B11, input_B12, input_B21, input_B22  in  32 each  matrix B elements (binary32).
REQ-008 output_Stable  out  1  registered; high while C holds a complete, valid result.
REQ-009 output_C11, output_C12, output_C21, output_C22  out  32 each  registered result elements; Cij = Aij + Bij.

Function
REQ-010 FSM states SHALL be IDLE, CALC and DONE.
REQ-011 In IDLE, with input_Start sampled high, the block SHALL capture all eight A/B inputs into internal registers, clear the element index to 0, and enter CALC.
REQ-012 In CALC, the block SHALL compute one element per cycle with a single shared adder, in the order C11, C12, C21, C22, writing each result to its output register at the end of that cycle.
REQ-013 After C22 is written, the block SHALL enter DONE, and output_Stable SHALL be high from that edge on, i.e. 4 cycles after the edge at which Start was sampled.
REQ-014 In DONE, output_Stable and all C outputs SHALL hold until input_C_Ack is sampled high; the block SHALL then return to IDLE with output_Stable low from the next cycle.
REQ-015 input_Start SHALL be ignored in CALC and DONE; input_C_Ack SHALL be ignored in IDLE and CALC.
REQ-016 If Start and C_Ack are both high in DONE, the block SHALL take the Ack and go to IDLE; a Start still held high SHALL then begin a new operation at the following edge.
REQ-017 Changes on the A/B inputs after capture SHALL NOT affect the current operation.
REQ-018 C outputs SHALL retain their last values in IDLE; in CALC they update element by element and are valid only while output_Stable is high.
REQ-019 Each addition SHALL be IEEE-754 binary32 with round-to-nearest-even, including alignment with guard, round and sticky bits, and renormalisation after carry-out or cancellation.
REQ-020 Any NaN operand, or +inf plus -inf, SHALL produce 0x7FC00000.
REQ-021 A single infinity operand SHALL propagate that infinity, and exponent overflow SHALL produce a correctly signed infinity.
REQ-022 An exact-zero sum SHALL be +0, except (-0)+(-0), which SHALL be -0.

Reset
REQ-023 With input_Reset high at a clock edge, the block SHALL enter IDLE, set output_Stable to 0, set all C outputs and captured operands to 0x00000000, and clear the index; this applies from any state, including mid-CALC, and discards the operation in progress.
REQ-024 Reset SHALL take priority over Start and C_Ack.

Configuration
REQ-025 With macro AXA_DENORMAL_EN defined, subnormal operands and results SHALL be handled with gradual underflow per IEEE-754.
REQ-026 Without AXA_DENORMAL_EN, subnormal operands SHALL be treated as correctly signed zero and subnormal results SHALL be flushed to correctly signed zero; all other behaviour is identical.

Verification
REQ-027 Reset, then Start with A=(0x42FA0000, 0x3EE04189, 0x420A28F6, 0x4148BC6A) and B=(0x3A635B85, 0x44961DC3, 0x41980000, 0x3FAB851F) -> output_Stable high 4 cycles later; C equals the correctly rounded sums, ≈(125.0008673, 1201.368, 53.54, 13.886), bit-exact against a reference model.
REQ-028 Element additions 0x3F800000+0x40000000, 0x3FC00000+0xBFC00000, 0x7F7FFFFF+0x7F7FFFFF, 0x7F800000+0xFF800000 -> results 0x40400000, 0x00000000, 0x7F800000, 0x7FC00000.
REQ-029 Stable high with C_Ack low for 10 cycles while the A/B inputs change -> C and Stable unchanged; pulse C_Ack -> Stable low next cycle.
REQ-030 Reset asserted in the 2nd CALC cycle -> next cycle Stable=0 and all C=0; after Reset is released, a new Start completes normally.
REQ-031 Start held high continuously -> operations repeat; each completes only after its C_Ack, with Stable low at least one cycle between results.
REQ-032 Element addition 0x00400000+0x00400000 -> 0x00800000 with AXA_DENORMAL_EN defined; 0x00000000 without it.
